// File: rtl/cpu_datapath.sv
// Datapath for the simple 16-bit CPU: IR, register file, A/B/C pipeline registers, shifter, ALU and status flags.
// All outputs are registered; the FSM controller sequences every load and write.
module cpu_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load_ir,
  input  logic [3:0]       vsel,
  input  logic             asel,
  input  logic             bsel,
  input  logic [2:0]       nsel,
  input  logic             loada,
  input  logic             loadb,
  input  logic             loadc,
  input  logic             loads,
  input  logic             write,
  input  logic [WIDTH-1:0] mdata,
  input  logic [7:0]       PC,
  output logic [2:0]       opcode,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] datapath_out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] rf [0:7];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic             z_reg, n_reg, v_reg;

  logic [2:0]       rn, rd, rm, reg_num;
  logic [1:0]       sh;
  logic [WIDTH-1:0] sximm8, sximm5;
  logic [WIDTH-1:0] read_data, write_data;
  logic [WIDTH-1:0] b_shift, alu_a, alu_b, alu_res;
  logic             alu_z, alu_n, alu_v;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};

  // Illegal nsel codes fall back to R0 rather than merging register numbers.
  always_comb begin
    reg_num = 3'd0;
    case (nsel)
      3'b001:  reg_num = rn;
      3'b010:  reg_num = rd;
      3'b100:  reg_num = rm;
      default: reg_num = 3'd0;
    endcase
  end

  assign read_data = rf[reg_num];

  always_comb begin
    write_data = '0;
    case (vsel)
      4'b1000: write_data = mdata;
      4'b0100: write_data = sximm8;
      4'b0010: write_data = {{(WIDTH-8){1'b0}}, PC};
      4'b0001: write_data = c_reg;
      default: write_data = '0;
    endcase
  end

  always_comb begin
    b_shift = b_reg;
    case (sh)
      2'b00: b_shift = b_reg;
      2'b01: b_shift = {b_reg[WIDTH-2:0], 1'b0};
      2'b10: b_shift = {1'b0, b_reg[WIDTH-1:1]};
      2'b11: b_shift = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
    endcase
  end

  assign alu_a = asel ? '0 : a_reg;
  assign alu_b = bsel ? sximm5 : b_shift;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op)
      2'b00: begin
        alu_res = alu_a + alu_b;
        alu_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      2'b01: begin
        alu_res = alu_a - alu_b;
        alu_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      2'b10: alu_res = alu_a & alu_b;
      2'b11: alu_res = ~alu_b;
    endcase
  end

  assign alu_z = (alu_res == '0);
  assign alu_n = alu_res[WIDTH-1];

  // Reset wins over every load and write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= '0;
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      z_reg <= 1'b0;
      n_reg <= 1'b0;
      v_reg <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (load_ir) ir <= in;
      if (loada)   a_reg <= read_data;
      if (loadb)   b_reg <= read_data;
      if (loadc)   c_reg <= alu_res;
      if (loads) begin
        z_reg <= alu_z;
        n_reg <= alu_n;
        v_reg <= alu_v;
      end
      if (write) rf[reg_num] <= write_data;
    end
  end

  assign datapath_out = c_reg;
  assign Z = z_reg;
  assign N = n_reg;
  assign V = v_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load_ir;
  logic [3:0]  vsel;
  logic        asel, bsel;
  logic [2:0]  nsel;
  logic        loada, loadb, loadc, loads, write;
  logic [15:0] mdata;
  logic [7:0]  PC;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [15:0] datapath_out;
  logic        Z, N, V;

  int vecs = 0;
  int errs = 0;

  cpu_datapath #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load_ir(load_ir), .vsel(vsel),
    .asel(asel), .bsel(bsel), .nsel(nsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .mdata(mdata), .PC(PC),
    .opcode(opcode), .op(op), .datapath_out(datapath_out), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    reset = 0; load_ir = 0; vsel = 4'b0000; asel = 0; bsel = 0; nsel = 3'b000;
    loada = 0; loadb = 0; loadc = 0; loads = 0; write = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_ir(input logic [15:0] w);
    clr(); in = w; load_ir = 1; cyc(); load_ir = 0;
  endtask

  task automatic wr(input logic [3:0] vs, input logic [2:0] ns);
    clr(); vsel = vs; nsel = ns; write = 1; cyc(); clr();
  endtask

  task automatic ld_reg(input logic [2:0] ns, input logic la, input logic lb);
    clr(); nsel = ns; loada = la; loadb = lb; cyc(); clr();
  endtask

  // Copies register r into C through B (ADD with A forced to zero, no shift).
  task automatic rd_c(input logic [2:0] r);
    ld_ir({13'b1010000000000, r});
    ld_reg(3'b100, 1'b0, 1'b1);
    asel = 1; loadc = 1; cyc(); clr();
  endtask

  task automatic test_reset();
    clr(); reset = 1; in = 16'h0000; mdata = 16'h0000; PC = 8'h00;
    cyc(); cyc(); clr();
    vecs++; if (opcode !== 3'b000) begin errs++; $display("FAIL reset_opcode got %b want 000", opcode); end
    vecs++; if (op !== 2'b00) begin errs++; $display("FAIL reset_op got %b want 00", op); end
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL reset_out got %h want 0000", datapath_out); end
    vecs++; if ({Z, N, V} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {Z, N, V}); end
  endtask

  task automatic test_mov();
    ld_ir(16'hD107);
    vecs++; if (opcode !== 3'b110) begin errs++; $display("FAIL mov_opcode got %b want 110", opcode); end
    vecs++; if (op !== 2'b10) begin errs++; $display("FAIL mov_op got %b want 10", op); end
    wr(4'b0100, 3'b001);
    ld_ir(16'hD2FE);
    wr(4'b0100, 3'b001);
    rd_c(3'd1);
    vecs++; if (datapath_out !== 16'h0007) begin errs++; $display("FAIL mov_r1 got %h want 0007", datapath_out); end
    rd_c(3'd2);
    vecs++; if (datapath_out !== 16'hFFFE) begin errs++; $display("FAIL mov_r2 got %h want fffe", datapath_out); end
  endtask

  task automatic test_add_shift();
    ld_ir(16'hA16A);
    ld_reg(3'b100, 1'b0, 1'b1);
    ld_reg(3'b001, 1'b1, 1'b0);
    loadc = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'h0003) begin errs++; $display("FAIL add_lsl got %h want 0003", datapath_out); end
    wr(4'b0001, 3'b010);
    rd_c(3'd3);
    vecs++; if (datapath_out !== 16'h0003) begin errs++; $display("FAIL add_wb_r3 got %h want 0003", datapath_out); end
  endtask

  task automatic test_cmp();
    ld_ir(16'hA901);
    ld_reg(3'b100, 1'b0, 1'b1);
    ld_reg(3'b001, 1'b1, 1'b0);
    loads = 1; cyc(); clr();
    vecs++; if ({Z, N, V} !== 3'b100) begin errs++; $display("FAIL cmp_flags got %b want 100", {Z, N, V}); end
    vecs++; if (datapath_out !== 16'h0003) begin errs++; $display("FAIL cmp_c_held got %h want 0003", datapath_out); end
  endtask

  task automatic test_overflow();
    ld_ir(16'hA500);
    mdata = 16'h7FFF;
    wr(4'b1000, 3'b001);
    mdata = 16'h0000;
    ld_ir(16'hA5C5);
    ld_reg(3'b100, 1'b0, 1'b1);
    ld_reg(3'b001, 1'b1, 1'b0);
    loadc = 1; loads = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'hFFFE) begin errs++; $display("FAIL add_ovf_c got %h want fffe", datapath_out); end
    vecs++; if ({Z, N, V} !== 3'b011) begin errs++; $display("FAIL add_ovf_flags got %b want 011", {Z, N, V}); end
    // 7FFF - (-2) overflows the signed range
    ld_ir(16'hAD02);
    ld_reg(3'b001, 1'b1, 1'b0);
    ld_reg(3'b100, 1'b0, 1'b1);
    loadc = 1; loads = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'h8001) begin errs++; $display("FAIL sub_ovf_c got %h want 8001", datapath_out); end
    vecs++; if ({Z, N, V} !== 3'b011) begin errs++; $display("FAIL sub_ovf_flags got %b want 011", {Z, N, V}); end
  endtask

  task automatic test_mvn_asel();
    ld_ir(16'hB803);
    bsel = 1; loadc = 1; loads = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'hFFFC) begin errs++; $display("FAIL mvn_c got %h want fffc", datapath_out); end
    vecs++; if ({Z, N, V} !== 3'b010) begin errs++; $display("FAIL mvn_flags got %b want 010", {Z, N, V}); end
    ld_ir(16'hD405);
    wr(4'b0100, 3'b001);
    ld_ir(16'hA01C);
    ld_reg(3'b100, 1'b0, 1'b1);
    asel = 1; loadc = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'h0002) begin errs++; $display("FAIL asr_pos got %h want 0002", datapath_out); end
    ld_ir(16'hA01A);
    ld_reg(3'b100, 1'b0, 1'b1);
    asel = 1; loadc = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'hFFFF) begin errs++; $display("FAIL asr_neg got %h want ffff", datapath_out); end
    ld_ir(16'hB112);
    ld_reg(3'b100, 1'b0, 1'b1);
    ld_reg(3'b001, 1'b1, 1'b0);
    loadc = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'h0007) begin errs++; $display("FAIL and_lsr got %h want 0007", datapath_out); end
  endtask

  task automatic test_writeback_sel();
    ld_ir(16'hD600);
    PC = 8'hA5;
    wr(4'b0010, 3'b001);
    PC = 8'h00;
    rd_c(3'd6);
    vecs++; if (datapath_out !== 16'h00A5) begin errs++; $display("FAIL pc_wb got %h want 00a5", datapath_out); end
    ld_ir(16'hD1AB);
    wr(4'b0100, 3'b000);
    rd_c(3'd0);
    vecs++; if (datapath_out !== 16'hFFAB) begin errs++; $display("FAIL nsel_bad_r0 got %h want ffab", datapath_out); end
    rd_c(3'd1);
    vecs++; if (datapath_out !== 16'h0007) begin errs++; $display("FAIL nsel_bad_r1 got %h want 0007", datapath_out); end
    ld_ir(16'hD1AB);
    wr(4'b0101, 3'b011);
    rd_c(3'd0);
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL vsel_multi got %h want 0000", datapath_out); end
  endtask

  task automatic test_hold();
    rd_c(3'd6);
    clr(); in = 16'hFFFF; mdata = 16'h1234; PC = 8'h77;
    repeat (5) cyc();
    vecs++; if (datapath_out !== 16'h00A5) begin errs++; $display("FAIL hold_c got %h want 00a5", datapath_out); end
    vecs++; if ({opcode, op} !== 5'b10100) begin errs++; $display("FAIL hold_ir got %b want 10100", {opcode, op}); end
    vecs++; if ({Z, N, V} !== 3'b010) begin errs++; $display("FAIL hold_flags got %b want 010", {Z, N, V}); end
    rd_c(3'd6);
    vecs++; if (datapath_out !== 16'h00A5) begin errs++; $display("FAIL hold_r6 got %h want 00a5", datapath_out); end
  endtask

  task automatic test_reset_priority();
    rd_c(3'd3);
    vecs++; if (datapath_out !== 16'h0003) begin errs++; $display("FAIL pre_reset_c got %h want 0003", datapath_out); end
    ld_ir(16'hD3AB);
    clr(); reset = 1; write = 1; vsel = 4'b0100; nsel = 3'b001; loadc = 1; loads = 1;
    load_ir = 1; in = 16'hFFFF; loada = 1; loadb = 1;
    cyc(); clr();
    vecs++; if ({opcode, op} !== 5'b00000) begin errs++; $display("FAIL rstp_ir got %b want 00000", {opcode, op}); end
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL rstp_c got %h want 0000", datapath_out); end
    vecs++; if ({Z, N, V} !== 3'b000) begin errs++; $display("FAIL rstp_flags got %b want 000", {Z, N, V}); end
    rd_c(3'd3);
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL rstp_r3 got %h want 0000", datapath_out); end
    rd_c(3'd6);
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL rstp_r6 got %h want 0000", datapath_out); end
  endtask

  task automatic test_back_to_back();
    ld_ir(16'hD1AB);
    clr(); vsel = 4'b0100; nsel = 3'b001; write = 1; loadb = 1; cyc(); clr();
    ld_ir(16'hA000);
    asel = 1; loadc = 1; cyc(); clr();
    vecs++; if (datapath_out !== 16'h0000) begin errs++; $display("FAIL rw_old_b got %h want 0000", datapath_out); end
    rd_c(3'd1);
    vecs++; if (datapath_out !== 16'hFFAB) begin errs++; $display("FAIL rw_new_r1 got %h want ffab", datapath_out); end
  endtask

  initial begin
    clr(); in = 16'h0000; mdata = 16'h0000; PC = 8'h00;
    test_reset();
    test_mov();
    test_add_shift();
    test_cmp();
    test_overflow();
    test_mvn_asel();
    test_writeback_sel();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath that consumes the control word from the lab 6 FSM controller. The FSM drives vsel, asel, bsel, nsel, loada, loadb, loadc, loads and write; this block executes them.
- Contains:
  - an instruction register plus field decoder, which returns opcode and op to the FSM;
  - an 8x16 register file;
  - pipeline registers A, B and C;
  - a shifter and an ALU;
  - a Z/N/V status register.
- Together with the FSM it forms the simple 16-bit CPU.

Parameters:
- WIDTH, 16, datapath word width. Instruction field positions assume 16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  16  instruction word
- load_ir  input  1  captures in into the IR on the rising edge
- vsel  input  4  one-hot writeback source: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C
- asel  input  1  1: ALU A operand is 0; 0: A register
- bsel  input  1  1: ALU B operand is sximm5; 0: shifted B register
- nsel  input  3  one-hot register-number select: 001=Rn, 010=Rd, 100=Rm
- loada  input  1  load A from the register-file read port
- loadb  input  1  load B from the register-file read port
- loadc  input  1  load C from the ALU result
- loads  input  1  load status from ALU flags
- write  input  1  write writeback data into the selected register
- mdata  input  16  memory data (writeback source)
- PC  input  8  program counter, zero-extended for writeback
- opcode  output  3  IR[15:13]
- op  output  2  IR[12:11]
- datapath_out  output  16  C register
- Z  output  1  status zero
- N  output  1  status negative
- V  output  1  status overflow

Behaviour:

IR fields:
- Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
- sximm8 = sign-extended [7:0]; sximm5 = sign-extended [4:0].

Register select:
- nsel picks Rn, Rd or Rm.
- Any nsel not in {001, 010, 100} selects R0.

Register file:
- Combinational read of the selected register.
- Write on the rising edge when write=1.
- Read and write in the same cycle: loads capture the pre-write value. The new value is visible from the next cycle.

Writeback mux:
- Zero or multi-hot vsel gives 16'h0000 as write data.

Pipeline registers:
- A and B capture read data on the edge when loada/loadb=1.
- Both may load in the same cycle and receive identical data.
- C captures the ALU result when loadc=1.
- Status captures Z/N/V when loads=1, independent of loadc.

Shifter (applied to B, controlled by sh):
- 00: pass.
- 01: LSL1, LSB=0.
- 10: LSR1, MSB=0.
- 11: ASR1, MSB kept.

ALU (op selects):
- 00: A+B mod 2^16.
- 01: A-B.
- 10: A&B.
- 11: ~B.

Flags:
- Z=(result==0); N=result[15].
- V=1 on signed overflow for add/sub only:
  - add: operands of equal sign, result sign differs;
  - sub: operands of differing sign, result sign differs from A.
- V=0 for AND and MVN.

Reset:
- On an edge with reset=1, IR, A, B, C, Z, N, V and R0-R7 are all set to 0.
- Reset overrides every simultaneous load or write; there is no partial update mid-instruction.
- After reset: opcode=000, op=00, datapath_out=0000, Z=N=V=0.

Latency:
- All outputs are registered. opcode and op change 1 cycle after load_ir.
- One instruction sequence spans the FSM's states. This block has no internal state machine beyond its registers; it must never self-advance.

Undriven controls (all loads and write low):
- Every register holds its value indefinitely.

Test Plan:
1. MOV immediate:
   - reset; in=16'hD107, load_ir=1 → opcode=110, op=10.
   - vsel=0100, nsel=001, write=1 → R1=0007.
   - Repeat with 16'hD2FE → R2=FFFE.
2. ADD with shift:
   - IR=16'hA16A (ADD R3,R1,R2,LSL1).
   - nsel=100, loadb; nsel=001, loada; loadc → datapath_out=0003.
   - vsel=0001, nsel=010, write → R3=0003.
3. CMP:
   - IR=16'hA901 (CMP R1,R1); load B and A from R1; loads=1 → Z=1, N=0, V=0.
   - C is unchanged from the previous scenario when loadc=0.
4. Overflow:
   - mdata=7FFF, vsel=1000, nsel=001, write with IR Rn=5 → R5=7FFF.
   - IR=16'hA5C5; load A and B from R5; loadc and loads → C=FFFE, N=1, V=1, Z=0.
5. MVN and asel/bsel:
   - IR op=11 with imm5=00011; bsel=1, loadc → C=FFFC.
   - IR op=00, asel=1, bsel=0, B=0005, sh=11 → C=0002.
6. Reset priority:
   - With C=0003 and R3=0003, assert reset together with write=1, vsel=0100 and loadc=1.
   - Next cycle → all outputs 0, R3=0000; register-file readback via loadb then loadc (asel=1) gives 0000.
   - Same-cycle read/write of R1 → B receives the old value.
